// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
//
// Serial W-bit adder (W = 4*NIBBLES) built around a single 4-bit ripple slice.
// Operands are latched on an accepted start. One nibble is processed per cycle,
// least-significant nibble first. The result is loaded into sum/cout/ovf on the
// clock edge that finishes the last nibble, and done pulses for one cycle.
//
// Configuration macro:
//   SUB_MODE_EN  - when defined, op=1 computes A - B as A + ~B + 1. In that case
//                  cin is ignored and cout=1 means no borrow. When undefined,
//                  op is ignored and the block always computes A + B + cin.
//
// Parameters:
//   NIBBLES  number of 4-bit slices per operand (2..8), W = 4*NIBBLES
//
// Ports:
//   clk     sole clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   request; accepted in IDLE or DONE, ignored while busy
//   a, b    W-bit operands
//   cin     carry-in for add
//   op      0 = add, 1 = subtract (only with SUB_MODE_EN)
//   busy    high for exactly the NIBBLES cycles of a computation
//   done    single-cycle completion pulse
//   sum     registered W-bit result (modulo 2^W)
//   cout    carry out of the final slice
//   ovf     signed two's-complement overflow
// -----------------------------------------------------------------------------
module add_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  input  logic                   op,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_sr;      // operand A, shifted right one nibble per cycle
  logic [W-1:0]    b_sr;      // operand B, shifted right one nibble per cycle
  logic [W-5:0]    part;      // finished nibbles, newest at the top
  logic            carry;     // carry into the next slice
  logic            sub_q;     // subtract mode latched with the operands
  logic [CW-1:0]   cnt;       // index of the nibble now in the slice

  // Decode of the requested operation at acceptance time.
  logic sub_in;
  logic eff_cin;

`ifdef SUB_MODE_EN
  assign sub_in  = op;
  assign eff_cin = op ? 1'b1 : cin;
`else
  logic unused_op;
  assign unused_op = op;
  assign sub_in    = 1'b0;
  assign eff_cin   = cin;
`endif

  // The single 4-bit ripple slice.
  logic [3:0]   b_nib;
  logic [3:0]   slice_s;
  logic         slice_co;
  logic [W-1:0] full;       // the final result if this is the last nibble
  logic         slice_ovf;

  // NOTE: every signal written here gets a value before any condition,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    b_nib               = b_sr[3:0] ^ {4{sub_q}};
    {slice_co, slice_s} = {1'b0, a_sr[3:0]} + {1'b0, b_nib} + {4'b0000, carry};
    full                = {slice_s, part};
    // On the last nibble the slice inputs carry the operand MSBs, so the
    // overflow test uses them directly instead of keeping copies.
    slice_ovf           = (a_sr[3] == b_nib[3]) && (slice_s[3] != a_sr[3]);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      // NOTE: the operand and partial registers are reset as well; they are
      // few flops and it keeps the datapath free of X after reset.
      a_sr  <= '0;
      b_sr  <= '0;
      part  <= '0;
      sub_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= eff_cin;
            sub_q <= sub_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          a_sr  <= a_sr >> 4;
          b_sr  <= b_sr >> 4;
          carry <= slice_co;
          part  <= full[W-1:4];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= full;
            cout  <= slice_co;
            ovf   <= slice_ovf;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_seq_ctrl
//
// Self-checking bench for add_seq_ctrl with NIBBLES=4. A behavioural model
// computes each result with plain W+1-bit arithmetic at acceptance and tracks
// the cycle distance since acceptance; a compare process checks every output
// on every falling edge outside reset. Directed vectors add hand-computed
// literal expectations. Honours SUB_MODE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_add_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

`ifdef SUB_MODE_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         op    = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_pass  = 0;
  int n_total = 0;

  add_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  function automatic res_t model_op(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                    input logic fcin, input logic fop);
    res_t         r;
    logic [W-1:0] beff;
    logic         c;
    logic [W:0]   tot;
    if (SUB_EN && fop) begin
      beff = ~fb;
      c    = 1'b1;
    end else begin
      beff = fb;
      c    = fcin;
    end
    tot = {1'b0, fa} + {1'b0, beff} + {{W{1'b0}}, c};
    r.s = tot[W-1:0];
    r.c = tot[W];
    r.v = (fa[W-1] == beff[W-1]) && (r.s[W-1] != fa[W-1]);
    return r;
  endfunction

  // m_age: -1 = no computation, 0..NIB-1 = busy cycles, NIB = done cycle.
  int   m_age = -1;
  res_t m_pend = '0;
  res_t m_out  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= -1;
      m_out <= '0;
    end else if (m_age == -1 || m_age == NIB) begin
      if (start) begin
        m_age  <= 0;
        m_pend <= model_op(a, b, cin, op);
      end else begin
        m_age <= -1;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age == NIB - 1) m_out <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_busy", 32'(busy), 32'(m_age >= 0 && m_age < NIB));
      check("m_done", 32'(done), 32'(m_age == NIB));
      check("m_sum",  32'(sum),  32'(m_out.s));
      check("m_cout", 32'(cout), 32'(m_out.c));
      check("m_ovf",  32'(ovf),  32'(m_out.v));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // One start pulse; inputs are scrambled right after acceptance. Expects
  // done on the 5th falling edge after the accepting edge and 4 busy cycles.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic to, input logic [W-1:0] es,
                        input logic ec, input logic ev);
    int lat    = 0;
    int busy_n = 0;
    a = ta; b = tb_v; cin = tc; op = to; start = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        a = ~ta; b = ta ^ tb_v; cin = ~tc; op = ~to;
      end
      if (busy) busy_n++;
    end while (!done && lat < 20);
    check({name, "_latency"}, 32'(lat),    32'd5);
    check({name, "_busy_n"},  32'(busy_n), 32'd4);
    check({name, "_sum"},     32'(sum),    32'(es));
    check({name, "_cout"},    32'(cout),   32'(ec));
    check({name, "_ovf"},     32'(ovf),    32'(ev));
  endtask

  initial begin : timeout
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int saw_done;
    int first_done;
    int second_done;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef SUB_MODE_EN
    run_op("sub57",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("subovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`else
    run_op("sub57",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
    run_op("subovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0);
`endif
    run_op("negovf",  16'h8001, 16'h8001, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1);

    // Reset in the second RUN cycle: outputs clear at once, no done pulse.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_op("after_rst", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);

    // start held during RUN with changing operands is ignored; start in the
    // DONE cycle launches the next computation.
    a = 16'h1000; b = 16'h0234; cin = 1'b0; op = 1'b0; start = 1'b1;
    first_done  = 0;
    second_done = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done && first_done == 0) first_done = i;
      else if (done) second_done = i;
      if (i == 5) begin
        check("b2b_sum1", 32'(sum), 32'h1234);
        a = 16'h0F0F; b = 16'h0101; start = 1'b1;
      end else if (i < 5) begin
        a = 16'(16'hABCD * i); b = 16'(16'h1357 + i); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 10) check("b2b_sum2", 32'(sum), 32'h1010);
    end
    check("b2b_first",  32'(first_done),  32'd5);
    check("b2b_second", 32'(second_done), 32'd10);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
